// File: rtl/fft_output_serializer.sv
// fft_output_serializer
//   Captures one packed complex FFT frame (buffer_size bins, real + imag)
//   through a valid/ready handshake and streams it out one bin per accepted
//   transfer in bin order 0..buffer_size-1.
//
// Ports
//   clk, reset          clock, asynchronous active-high reset
//   frame_valid/ready   frame capture handshake (ready only in IDLE)
//   frame_real/imag     packed frame, bin k at [k*sample_size +: sample_size]
//   sample_valid/ready  output bin handshake
//   sample_real/imag    current bin (zero when not valid)
//   sample_index        current bin number
//   sample_last         high with bin buffer_size-1
//   sample_mag          |re|+|im| of current bin
//
// Build option
//   FFT_SER_MAG_EN      when defined, sample_mag is computed; otherwise it
//                       is tied to zero (port present in both builds).
module fft_output_serializer #(
    parameter int buffer_size = 32,
    parameter int sample_size = 32,
    localparam int index_w    = $clog2(buffer_size)
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic                                 frame_valid,
    output logic                                 frame_ready,
    input  logic [buffer_size*sample_size-1:0]   frame_real,
    input  logic [buffer_size*sample_size-1:0]   frame_imag,
    output logic                                 sample_valid,
    input  logic                                 sample_ready,
    output logic signed [sample_size-1:0]        sample_real,
    output logic signed [sample_size-1:0]        sample_imag,
    output logic [index_w-1:0]                   sample_index,
    output logic                                 sample_last,
    output logic [sample_size:0]                 sample_mag
);

    typedef enum logic {IDLE = 1'b0, STREAM = 1'b1} state_t;

    state_t                                  state, state_nxt;
    logic [index_w-1:0]                      index, index_nxt;
    logic [buffer_size-1:0][sample_size-1:0] re_q, im_q;
    logic                                    capture;
    logic                                    last_bin;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            index <= '0;
            re_q  <= '0;
            im_q  <= '0;
        end else begin
            state <= state_nxt;
            index <= index_nxt;
            if (capture) begin
                re_q <= frame_real;
                im_q <= frame_imag;
            end
        end
    end

    always_comb begin
        state_nxt    = state;
        index_nxt    = index;
        frame_ready  = 1'b0;
        sample_valid = 1'b0;
        capture      = 1'b0;
        last_bin     = (index == index_w'(buffer_size - 1));
        case (state)
            IDLE: begin
                frame_ready = 1'b1;
                if (frame_valid) begin
                    capture   = 1'b1;
                    index_nxt = '0;
                    state_nxt = STREAM;
                end
            end
            STREAM: begin
                sample_valid = 1'b1;
                if (sample_ready) begin
                    if (last_bin) begin
                        index_nxt = '0;
                        state_nxt = IDLE;
                    end else begin
                        index_nxt = index + 1'b1;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
        sample_last = sample_valid && last_bin;
    end

    // Data is gated by valid so IDLE shows zeros rather than the stale frame.
    assign sample_real  = sample_valid ? re_q[index] : '0;
    assign sample_imag  = sample_valid ? im_q[index] : '0;
    assign sample_index = index;

`ifdef FFT_SER_MAG_EN
    // Widen by one bit before negating so -2^(sample_size-1) does not wrap.
    logic signed [sample_size:0] re_x, im_x;
    logic        [sample_size:0] re_abs, im_abs;

    assign re_x       = {sample_real[sample_size-1], sample_real};
    assign im_x       = {sample_imag[sample_size-1], sample_imag};
    assign re_abs     = re_x[sample_size] ? -re_x : re_x;
    assign im_abs     = im_x[sample_size] ? -im_x : im_x;
    assign sample_mag = re_abs + im_abs;
`else
    assign sample_mag = '0;
`endif

endmodule

// File: tb/tb_fft_output_serializer.sv
// Directed bench for fft_output_serializer (buffer_size=8, sample_size=16).
module tb_fft_output_serializer;
    localparam int NB = 8;
    localparam int SW = 16;

    logic                 clk, reset;
    logic                 frame_valid, frame_ready;
    logic [NB*SW-1:0]     frame_real, frame_imag;
    logic                 sample_valid, sample_ready;
    logic signed [SW-1:0] sample_real, sample_imag;
    logic [2:0]           sample_index;
    logic                 sample_last;
    logic [SW:0]          sample_mag;

    int checks   = 0;
    int failures = 0;

    fft_output_serializer #(.buffer_size(NB), .sample_size(SW)) dut (
        .clk(clk), .reset(reset),
        .frame_valid(frame_valid), .frame_ready(frame_ready),
        .frame_real(frame_real), .frame_imag(frame_imag),
        .sample_valid(sample_valid), .sample_ready(sample_ready),
        .sample_real(sample_real), .sample_imag(sample_imag),
        .sample_index(sample_index), .sample_last(sample_last),
        .sample_mag(sample_mag)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input longint got, input longint exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Hand-picked frame contents per test kind.
    function automatic int gen_re(input int kind, input int k);
        case (kind)
            0: return k * 100;
            1: return k * 10 + 1;
            2: return -1000 * k;
            default: return (k == 0) ? -32768 : (k == 1) ? 3 : k;
        endcase
    endfunction

    function automatic int gen_im(input int kind, input int k);
        case (kind)
            0: return -k;
            1: return 3 * k - 20;
            2: return 500 + k;
            default: return (k == 0) ? 32767 : (k == 1) ? -4 : -k;
        endcase
    endfunction

    function automatic int iabs(input int v);
        return (v < 0) ? -v : v;
    endfunction

    function automatic longint exp_mag(input int kind, input int k);
`ifdef FFT_SER_MAG_EN
        return longint'(iabs(gen_re(kind, k)) + iabs(gen_im(kind, k)));
`else
        return 0;
`endif
    endfunction

    task automatic pack(input int kind);
        for (int k = 0; k < NB; k++) begin
            frame_real[k*SW +: SW] = 16'(gen_re(kind, k));
            frame_imag[k*SW +: SW] = 16'(gen_im(kind, k));
        end
    endtask

    task automatic cap(input int kind);
        pack(kind);
        frame_valid = 1'b1;
        check("cap_ready", frame_ready, 1);
        @(posedge clk); #1;
        frame_valid = 1'b0;
    endtask

    // Consume a full frame; stall_n cycles of back-pressure at bin stall_at.
    task automatic run_stream(input int kind, input int stall_at, input int stall_n);
        int e = 0, cyc = 0, st = 0;
        while (e < NB && cyc < 60) begin
            check("valid", sample_valid, 1);
            check("fready_lo", frame_ready, 0);
            check("index", sample_index, e);
            check("real", sample_real, gen_re(kind, e));
            check("imag", sample_imag, gen_im(kind, e));
            check("last", sample_last, (e == NB - 1) ? 1 : 0);
            check("mag", sample_mag, exp_mag(kind, e));
            if (e == stall_at && st < stall_n) begin
                sample_ready = 1'b0;
                st++;
            end else begin
                sample_ready = 1'b1;
            end
            @(posedge clk); #1;
            if (sample_ready) e++;
            cyc++;
        end
        if (cyc >= 60) check("stream_timeout", 1, 0);
        check("stalls", st, stall_n);
        check("end_valid", sample_valid, 0);
        check("end_fready", frame_ready, 1);
        check("end_last", sample_last, 0);
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_fready"}, frame_ready, 1);
        check({tag, "_valid"}, sample_valid, 0);
        check({tag, "_last"}, sample_last, 0);
        check({tag, "_real"}, sample_real, 0);
        check({tag, "_imag"}, sample_imag, 0);
        check({tag, "_index"}, sample_index, 0);
        check({tag, "_mag"}, sample_mag, 0);
    endtask

    initial begin
        reset        = 1'b0;
        frame_valid  = 1'b0;
        sample_ready = 1'b0;
        frame_real   = '0;
        frame_imag   = '0;

        // Asynchronous reset mid-cycle.
        #3 reset = 1'b1;
        #1 check_idle("rst");
        repeat (2) @(posedge clk);
        #2 reset = 1'b0;
        repeat (3) @(posedge clk);
        #1 check_idle("idle");

        // Basic stream, ready held high.
        sample_ready = 1'b1;
        cap(0);
        run_stream(0, -1, 0);

        // Back-pressure at bin 3 for 3 cycles.
        cap(1);
        run_stream(1, 3, 3);

        // Second frame held on the bus during stream must wait.
        cap(2);
        pack(1);
        frame_valid = 1'b1;
        run_stream(2, -1, 0);
        @(posedge clk); #1;
        frame_valid = 1'b0;
        run_stream(1, -1, 0);

        // Reset while streaming at bin 5.
        cap(0);
        sample_ready = 1'b1;
        repeat (5) begin
            @(posedge clk); #1;
        end
        check("pre_rst_index", sample_index, 5);
        check("pre_rst_valid", sample_valid, 1);
        #2 reset = 1'b1;
        #1 check_idle("midrst");
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;
        check_idle("postrst");
        cap(2);
        run_stream(2, -1, 0);

        // Magnitude corner cases (max negative, mixed signs).
        cap(3);
        run_stream(3, 1, 2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/fft_output_serializer.md
# fft_output_serializer

Downstream of the FFT butterfly stage. It captures one complete packed complex frame (`buffer_size` bins, real and imaginary) with a valid/ready handshake and streams it out one bin per accepted transfer, in bin order 0..buffer_size-1. It decouples the wide combinational FFT result from the narrow consumers (magnitude/spectrum logic, UART/debug readout), and can compute an optional per-bin L1 magnitude.

## Interface
Parameters:
- `buffer_size`, 32, bins per frame; power of two, ≥2.
- `sample_size`, 32, signed bits per real/imag component.

Ports:
- `clk`  in  1  sole clock; all state on rising edge.
- `reset`  in  1  asynchronous, active-high; clears all state immediately.
- `frame_valid`  in  1  packed frame on `frame_real`/`frame_imag` is valid.
- `frame_ready`  out  1  block can capture a frame.
- `frame_real`  in  buffer_size*sample_size  signed; bin k at `[k*sample_size +: sample_size]`.
- `frame_imag`  in  buffer_size*sample_size  signed; same packing.
- `sample_valid`  out  1  output bin valid.
- `sample_ready`  in  1  consumer accepts the bin.
- `sample_real`  out  sample_size  signed real part of the current bin.
- `sample_imag`  out  sample_size  signed imaginary part of the current bin.
- `sample_index`  out  $clog2(buffer_size)  bin number of the current output.
- `sample_last`  out  1  high with bin buffer_size-1.
- `sample_mag`  out  sample_size+1  unsigned |re|+|im| (see Configuration).

## Operation
- The FSM has 2 states: IDLE and STREAM. Reset state is IDLE.
- IDLE: `frame_ready`=1, `sample_valid`=0. When `frame_valid`&&`frame_ready` is high at a rising edge, the block registers both frame buses into the internal frame store, sets index to 0, and moves to STREAM.
- STREAM: `frame_ready`=0, so input frames are back-pressured and not dropped. `sample_valid`=1.
  - Outputs show bin `index` from the stored frame.
  - On `sample_valid`&&`sample_ready`, index increments.
  - When the transfer carries `sample_last`, the block returns to IDLE and index goes to 0.
- Stall rule: while `sample_valid`=1 and `sample_ready`=0, all sample outputs hold stable.
- The frame store changes only on a frame capture. Changes on `frame_real`/`frame_imag` during STREAM are ignored.
- Magnitude arithmetic:
  - Each component is sign-extended to sample_size+1 bits before absolute value. The most negative input -2^(sample_size-1) therefore gives +2^(sample_size-1) and does not wrap.
  - The sum is sample_size+1 bits. Max is 2^sample_size, which fits exactly.
- Reset at any time, including mid-stream: go to IDLE, discard the stored frame, and clear all outputs.

## Timing
- Reset values:
  - `frame_ready`=1.
  - `sample_valid`=0, `sample_last`=0.
  - `sample_real`=0, `sample_imag`=0, `sample_index`=0, `sample_mag`=0.
  - Frame store is zeroed.
- Latency: frame captured at edge N, so bin 0 is valid after edge N (visible in cycle N+1).
- Throughput: 1 bin/cycle with `sample_ready` held high. A frame occupies buffer_size cycles of STREAM plus 1 IDLE cycle, so the frame period is buffer_size+1 cycles.
- `frame_ready` falls in the cycle after capture. It rises in the cycle after the last-bin handshake.
- `sample_last`=1 exactly when `sample_valid`=1 and index = buffer_size-1.
- Outputs come from the registered frame store and index through a mux. There is no combinational path from `sample_ready` to any output, and no path from `frame_valid` to `frame_ready`.

## Configuration
- Macro: `FFT_SER_MAG_EN`.
- Defined: `sample_mag` = |sample_real| + |sample_imag| for the current bin. It is computed combinationally from the stored bin and is valid with `sample_valid`.
- Undefined: no magnitude logic is built, and `sample_mag` is tied to 0. The port is present in both builds.

## Test plan
Benches use buffer_size=8, sample_size=16.
- Reset then idle: assert `reset` mid-cycle -> all outputs 0 and `frame_ready`=1 asynchronously; they stay so with `frame_valid`=0.
- Basic stream: capture a frame with real[k]=k*100 and imag[k]=-k, then hold `sample_ready`=1 -> 8 consecutive beats with index 0..7, real 0..700, imag 0..-7, `sample_last` only on beat 7. `frame_ready` returns 1 one cycle later.
- Back-pressure: drop `sample_ready` for 3 cycles at index 3 -> index 3 and its data held for 3 cycles, then 4..7 follow with no bin skipped or duplicated.
- Frame blocking: hold `frame_valid`=1 with a second frame during STREAM -> second frame is not captured until after the last bin, then captured in IDLE and streamed correctly. First-frame output is unaffected by changes on the input bus.
- Reset mid-stream: assert `reset` at index 5 -> `sample_valid`=0 and IDLE immediately. The next capture streams the new frame from index 0.
- With `FFT_SER_MAG_EN` defined: bin (re=-32768, im=32767) gives `sample_mag`=65535; bin (re=3, im=-4) gives 7. With the macro undefined, `sample_mag`=0 for both.
